// File: rtl/amm_resp_pkg.sv
`default_nettype none
// ============================================================================
// Package : amm_resp_pkg
// Shared types and constants for the Avalon-MM memory responder.
// Revision: 1.0
// ============================================================================
package amm_resp_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [31:0] DECODE_ERR_DATA   = 32'hDEAD_BEEF;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0800_0000;

endpackage
`default_nettype wire

// File: rtl/amm_read_delay_line.sv
`default_nettype none
// ============================================================================
// Module : amm_read_delay_line
// Fixed-latency valid+data shift register; data is zero in empty stages.
// Revision: 1.0
// ============================================================================
module amm_read_delay_line
  import amm_resp_pkg::*;
#(
  parameter int LATENCY   = 3,
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_valid,
  input  logic [DATAWIDTH-1:0] i_data,
  output logic                 o_valid,
  output logic [DATAWIDTH-1:0] o_data
);

  logic [LATENCY-1:0]   r_valid;
  logic [DATAWIDTH-1:0] r_data [LATENCY];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_valid ? i_data : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign o_valid = r_valid[LATENCY-1];
  assign o_data  = r_data[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/amm_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : amm_mem_responder
// Avalon-MM word-memory slave with waitrequest stalls and pipelined reads.
// Revision: 1.0
// ============================================================================
module amm_mem_responder
  import amm_resp_pkg::*;
#(
  parameter int                      ADDRESSWIDTH = 32,
  parameter int                      DATAWIDTH    = 32,
  parameter logic [ADDRESSWIDTH-1:0] BASE_ADDR    = ADDRESSWIDTH'(DEFAULT_BASE_ADDR),
  parameter int                      DEPTH_LOG2   = 6,
  parameter int                      WAIT_CYCLES  = 2,
  parameter int                      READ_LATENCY = 3,
  parameter int                      MAX_PENDING  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDRESSWIDTH-1:0]   avs_address,
  input  logic [DATAWIDTH/8-1:0]    avs_byteenable,
  input  logic                      avs_write,
  input  logic [DATAWIDTH-1:0]      avs_writedata,
  input  logic                      avs_read,
  output logic                      avs_waitrequest,
  output logic [DATAWIDTH-1:0]      avs_readdata,
  output logic                      avs_readdatavalid,
  output logic [7:0]                err_count
);

  localparam int                    c_BE_W         = DATAWIDTH / 8;
  localparam int                    c_WORDS        = 2 ** DEPTH_LOG2;
  localparam logic [ADDRESSWIDTH:0] c_WINDOW_BYTES = (ADDRESSWIDTH + 1)'(4 * c_WORDS);
  localparam int                    c_PEND_W       = $clog2(MAX_PENDING + 1);
  localparam logic [c_PEND_W-1:0]   c_MAX_PEND     = c_PEND_W'(MAX_PENDING);
  localparam logic [3:0]            c_WAIT         = 4'(WAIT_CYCLES);

  state_t                r_state;
  logic [3:0]            r_count;
  logic [c_PEND_W-1:0]   r_pending;
  logic [7:0]            r_err_count;
  logic [DATAWIDTH-1:0]  r_mem [c_WORDS];

  logic                  w_cmd;
  logic                  w_full;
  logic                  w_wait;
  logic                  w_accept;
  logic                  w_rd_accept;
  logic                  w_wr_accept;
  logic                  w_err;
  logic [ADDRESSWIDTH:0] w_offset;
  logic                  w_in_range;
  logic [DEPTH_LOG2-1:0] w_index;
  logic [DATAWIDTH-1:0]  w_rd_data;

  assign w_cmd      = avs_read | avs_write;
  assign w_full     = (r_pending == c_MAX_PEND);
  assign w_offset   = {1'b0, avs_address} - {1'b0, BASE_ADDR};
  assign w_in_range = (avs_address >= BASE_ADDR) && (w_offset < c_WINDOW_BYTES);
  assign w_index    = DEPTH_LOG2'(w_offset >> 2);
  assign w_rd_data  = w_in_range ? r_mem[w_index] : DATAWIDTH'(DECODE_ERR_DATA);

  // Full blocks on the registered count only; a return this cycle frees a slot next cycle.
  always_comb begin
    w_wait = 1'b0;
    if (WAIT_CYCLES == 0) begin
      w_wait = w_cmd & w_full;
    end else if (r_state == IDLE) begin
      w_wait = w_cmd;
    end else if (r_count != c_WAIT) begin
      w_wait = 1'b1;
    end else begin
      w_wait = w_full;
    end
  end

  assign w_accept        = w_cmd & ~w_wait;
  assign w_wr_accept     = w_accept & avs_write;
  assign w_rd_accept     = w_accept & avs_read & ~avs_write;
  assign w_err           = w_accept & ((avs_read & avs_write) | ~w_in_range);
  assign avs_waitrequest = w_wait;
  assign err_count       = r_err_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cmd && (WAIT_CYCLES != 0)) begin
            r_state <= STALL;
            r_count <= 4'd1;
          end
        end
        STALL: begin
          if (!w_cmd) begin
            r_state <= IDLE;
            r_count <= '0;
          end else if (r_count != c_WAIT) begin
            r_count <= r_count + 4'd1;
          end else if (!w_full) begin
            r_state <= IDLE;
            r_count <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < c_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_accept && w_in_range) begin
      for (int b = 0; b < c_BE_W; b++) begin
        if (avs_byteenable[b]) begin
          r_mem[w_index][b*8 +: 8] <= avs_writedata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pending   <= '0;
      r_err_count <= '0;
    end else begin
      if (w_rd_accept && !avs_readdatavalid) begin
        r_pending <= r_pending + c_PEND_W'(1);
      end else if (!w_rd_accept && avs_readdatavalid) begin
        r_pending <= r_pending - c_PEND_W'(1);
      end
      if (w_err && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  amm_read_delay_line #(
    .LATENCY   (READ_LATENCY),
    .DATAWIDTH (DATAWIDTH)
  ) u_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .i_valid (w_rd_accept),
    .i_data  (w_rd_data),
    .o_valid (avs_readdatavalid),
    .o_data  (avs_readdata)
  );

endmodule
`default_nettype wire
